out_arbiter: RTL and testbench

- Shares one router output port between the three channel FIFOs.
- Channel FIFOs expose committed packets only.
- Round-robin, packet-granular: once a channel is granted, its whole packet is sent (header + payload + optional CRC byte) before re-arbitration.
- Output handshake is req/ack; FIFO reads are show-ahead with pop.

---
 rtl/out_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_out_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_arbiter.sv
// out_arbiter: shares one router output port between three channel FIFOs.
// Packet-granular arbitration: a granted channel sends header, payload and
// optional CRC byte before the port is re-arbitrated. Output uses a registered
// req/ack handshake; FIFOs are show-ahead and popped in the ack cycle.
// Build option: define OUT_ARB_FIXED_PRIO_EN for fixed priority (ch0 > ch1 > ch2)
// instead of round-robin.
module out_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_SIZE  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            fifo_empty,
    output logic [2:0]            fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo0_data_out,
    input  logic [DATA_WIDTH-1:0] fifo1_data_out,
    input  logic [DATA_WIDTH-1:0] fifo2_data_out,
    input  logic                  crc_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_req,
    input  logic                  data_out_ack,
    output logic [2:0]            grant,
    output logic                  busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] SEND_HDR  = 3'd2;
    localparam logic [2:0] SEND_DATA = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    // One extra bit so max size plus CRC byte does not wrap to zero.
    localparam int unsigned CNT_W = DATA_SIZE + 1;

    logic [2:0]            state_q, state_d;
    logic [2:0]            grant_q, grant_d;
    logic [1:0]            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hdr_sent_q, hdr_sent_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  req_q, req_d;

    logic [1:0]            order [3];
    logic                  pick_valid;
    logic [1:0]            pick_idx;
    logic [1:0]            grant_idx;
    logic [DATA_WIDTH-1:0] head_byte;
    logic                  head_empty;
    logic                  accept;
    logic [CNT_W-1:0]      hdr_cnt;

    // Search order of channels for the next grant, highest priority first.
    always_comb begin
`ifdef OUT_ARB_FIXED_PRIO_EN
        order = '{2'd0, 2'd1, 2'd2};
`else
        unique case (last_grant_q)
            2'd0:    order = '{2'd1, 2'd2, 2'd0};
            2'd1:    order = '{2'd2, 2'd0, 2'd1};
            default: order = '{2'd0, 2'd1, 2'd2};
        endcase
`endif
    end

    // First non-empty channel in search order.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!pick_valid && !fifo_empty[order[k]]) begin
                pick_valid = 1'b1;
                pick_idx   = order[k];
            end
        end
    end

    // Head byte and emptiness of the granted FIFO; grant index for last_grant.
    always_comb begin
        head_byte  = '0;
        head_empty = 1'b1;
        grant_idx  = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);
        unique case (grant_q)
            3'b001: begin
                head_byte  = fifo0_data_out;
                head_empty = fifo_empty[0];
            end
            3'b010: begin
                head_byte  = fifo1_data_out;
                head_empty = fifo_empty[1];
            end
            3'b100: begin
                head_byte  = fifo2_data_out;
                head_empty = fifo_empty[2];
            end
            default: ;
        endcase
    end

    // A byte is consumed only when the sink acks a pending request.
    always_comb begin
        accept   = req_q && data_out_ack && ((state_q == SEND_HDR) || (state_q == SEND_DATA));
        fifo_pop = accept ? grant_q : 3'b000;
        hdr_cnt  = CNT_W'(data_out_q[DATA_SIZE-1:0]) + CNT_W'(crc_en);
    end

    // Next-state logic for the packet FSM and the output register.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        hdr_sent_d   = hdr_sent_q;
        data_out_d   = data_out_q;
        req_d        = req_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = 3'b001 << pick_idx;
                    hdr_sent_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // Hold off while the granted FIFO has nothing to show.
                if (!head_empty) begin
                    data_out_d = head_byte;
                    req_d      = 1'b1;
                    state_d    = hdr_sent_q ? SEND_DATA : SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (accept) begin
                    req_d      = 1'b0;
                    hdr_sent_d = 1'b1;
                    cnt_d      = hdr_cnt;
                    state_d    = (hdr_cnt == '0) ? DONE : LOAD;
                end
            end
            SEND_DATA: begin
                if (accept) begin
                    req_d   = 1'b0;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? DONE : LOAD;
                end
            end
            DONE: begin
                last_grant_d = grant_idx;
                grant_d      = 3'b000;
                req_d        = 1'b0;
                hdr_sent_d   = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                grant_d = 3'b000;
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 3'b000;
            last_grant_q <= 2'd2;
            cnt_q        <= '0;
            hdr_sent_q   <= 1'b0;
            data_out_q   <= '0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            hdr_sent_q   <= hdr_sent_d;
            data_out_q   <= data_out_d;
            req_q        <= req_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_out_req = req_q;
    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_out_arbiter.sv
// Testbench for out_arbiter: FIFO and sink models plus a packet-level
// reference model (arbitration order, byte stream, framing, DONE gap).
module tb_out_arbiter;

    localparam int DW = 8;
    localparam int DS = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    fifo_empty = 3'b111;
    logic [2:0]    fifo_pop;
    logic [DW-1:0] f0 = '0, f1 = '0, f2 = '0;
    logic          crc_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_out_req;
    logic          data_out_ack = 1'b0;
    logic [2:0]    grant;
    logic          busy;

    out_arbiter #(.DATA_WIDTH(DW), .DATA_SIZE(DS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_pop       (fifo_pop),
        .fifo0_data_out (f0),
        .fifo1_data_out (f1),
        .fifo2_data_out (f2),
        .crc_en         (crc_en),
        .data_out       (data_out),
        .data_out_req   (data_out_req),
        .data_out_ack   (data_out_ack),
        .grant          (grant),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // FIFO contents (committed packets only)
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] fq2[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         cur_ch = -1;
    int         last_win = 2;
    bit         hdr_pending = 0;
    bit         finishing = 0;
    int         done_age = 0;
    int         remaining = 0;
    int         pkt_bytes = 0;
    int         last_pkt_bytes = 0;
    int         pkts_done = 0;
    logic [2:0] prev_nonempty = 3'b000;
    int         grant_log[$];
    logic [7:0] byte_log[$];
    int         pop_cnt[3] = '{0, 0, 0};
    logic [2:0] pending_pop = 3'b000;
    bit         last_acc = 0;

    // Sink model state
    bit         armed = 0;
    int         sink_wait = 0;
    int         wait_cnt = 0;
    bit         ack_next = 0;
    bit         spur_next = 0;
    bit         force_ack = 0;
    int         dmin = 1, dmax = 1;
    int         spur_rate = 0;
    bit         wait_chk = 0;
    int         fixed_delay = 0;
    logic [7:0] held_byte = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] onehot(input int ch);
        return 3'b001 << ch;
    endfunction

    function automatic int rr_pick(input logic [2:0] ne, input int last);
`ifdef OUT_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++) if (ne[k]) return k;
`else
        for (int k = 1; k <= 3; k++) if (ne[(last + k) % 3]) return (last + k) % 3;
`endif
        return -1;
    endfunction

    function automatic int fifo_size(input int ch);
        case (ch)
            0:       return fq0.size();
            1:       return fq1.size();
            default: return fq2.size();
        endcase
    endfunction

    function automatic logic [7:0] fifo_head(input int ch);
        if (fifo_size(ch) == 0) return 8'h00;
        case (ch)
            0:       return fq0[0];
            1:       return fq1[0];
            default: return fq2[0];
        endcase
    endfunction

    task automatic update_fifo_if();
        fifo_empty = {fifo_size(2) == 0, fifo_size(1) == 0, fifo_size(0) == 0};
        f0 = fifo_head(0);
        f1 = fifo_head(1);
        f2 = fifo_head(2);
    endtask

    task automatic fifo_push(input int ch, input logic [7:0] b);
        case (ch)
            0:       fq0.push_back(b);
            1:       fq1.push_back(b);
            default: fq2.push_back(b);
        endcase
    endtask

    task automatic fifo_drop(input int ch);
        if (fifo_size(ch) == 0) return;
        case (ch)
            0:       void'(fq0.pop_front());
            1:       void'(fq1.pop_front());
            default: void'(fq2.pop_front());
        endcase
    endtask

    // Whole packet: header with random upper bits, size + crc payload bytes.
    task automatic push_pkt(input int ch, input int size, input bit with_crc);
        logic [7:0] hdr;
        hdr = 8'($urandom_range(255, 0));
        hdr[5:0] = 6'(size);
        fifo_push(ch, hdr);
        for (int i = 0; i < size + int'(with_crc); i++) fifo_push(ch, 8'($urandom_range(255, 0)));
        update_fifo_if();
    endtask

    task automatic model_reset();
        cur_ch = -1; last_win = 2; hdr_pending = 0; finishing = 0; done_age = 0;
        remaining = 0; pkt_bytes = 0; armed = 0; ack_next = 0; spur_next = 0;
        wait_cnt = 0; last_acc = 0; pending_pop = 3'b000;
    endtask

    // Observation and model update, done on the falling edge.
    task automatic monitor();
        logic       acc;
        logic [2:0] exp_pop;
        logic [7:0] hd;
        int         w;
        pending_pop = fifo_pop;
        if (!rst_n) begin
            prev_nonempty = ~fifo_empty;
            return;
        end
        acc = data_out_req && data_out_ack;
        if (finishing) begin
            done_age++;
            if (done_age == 1) begin
                check_eq("busy_in_done", busy, 1);
            end else begin
                check_eq("grant_idle", grant, 0);
                check_eq("busy_idle", busy, 0);
                last_win = cur_ch;
                cur_ch = -1;
                finishing = 0;
            end
        end else if (cur_ch < 0) begin
            if (grant != 3'b000) begin
                w = rr_pick(prev_nonempty, last_win);
                check_eq("grant_winner", grant, (w < 0) ? 3'b000 : onehot(w));
                if (w >= 0) begin
                    cur_ch = w;
                    hdr_pending = 1;
                    pkt_bytes = 0;
                    grant_log.push_back(w);
                end
            end
        end else begin
            check_eq("grant_hold", grant, onehot(cur_ch));
            check_eq("busy_pkt", busy, 1);
        end

        exp_pop = 3'b000;
        if (acc && cur_ch >= 0 && !finishing) exp_pop = onehot(cur_ch);
        check_eq("fifo_pop", fifo_pop, exp_pop);
        if (last_acc) check_eq("req_gap", data_out_req, 0);

        if (acc) begin
            if (cur_ch >= 0 && !finishing) begin
                hd = fifo_head(cur_ch);
                check_eq("data_out", data_out, hd);
                if (wait_chk) check_eq("ack_wait", wait_cnt, fixed_delay);
                byte_log.push_back(data_out);
                pkt_bytes++;
                if (hdr_pending) begin
                    hdr_pending = 0;
                    remaining = int'(hd[5:0]) + int'(crc_en);
                end else begin
                    remaining--;
                end
                if (remaining <= 0) begin
                    finishing = 1;
                    done_age = 0;
                    last_pkt_bytes = pkt_bytes;
                    pkts_done++;
                end
            end else begin
                check_eq("stray_req", data_out_req, 0);
            end
            armed = 0;
            wait_cnt = 0;
            if (spur_rate > 0 && $urandom_range(99, 0) < spur_rate) spur_next = 1;
        end else if (data_out_req) begin
            if (armed) begin
                check_eq("req_hold_data", data_out, held_byte);
            end else begin
                armed = 1;
                held_byte = data_out;
                sink_wait = $urandom_range(dmax, dmin);
            end
            wait_cnt++;
            if (sink_wait <= 1) ack_next = 1;
            else sink_wait--;
        end else if (armed) begin
            check_eq("req_dropped", data_out_req, 1);
            armed = 0;
            wait_cnt = 0;
        end
        last_acc = acc;
        prev_nonempty = ~fifo_empty;
    endtask

    // FIFO pops and sink drive, applied just after the rising edge.
    task automatic drive();
        for (int ch = 0; ch < 3; ch++) begin
            if (pending_pop[ch]) begin
                fifo_drop(ch);
                pop_cnt[ch]++;
            end
        end
        pending_pop = 3'b000;
        data_out_ack = ack_next || spur_next || force_ack;
        ack_next = 0;
        spur_next = 0;
        update_fifo_if();
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((fifo_size(0) + fifo_size(1) + fifo_size(2) != 0 || cur_ch >= 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        check_eq("drained", (fifo_size(0) + fifo_size(1) + fifo_size(2) == 0 && cur_ch < 0), 1);
        cycle();
        cycle();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        byte_log.delete();
        pop_cnt = '{0, 0, 0};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_order[6];
        int pops_before;
        logic [7:0] t1_bytes[4];

        update_fifo_if();
        cycle();
        cycle();
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_req", data_out_req, 0);
        check_eq("rst_pop", fifo_pop, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;
        cycle();

        // Round-robin across three channels, two 1-byte packets each
        clear_logs();
        crc_en = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            push_pkt(ch, 0, 0);
            push_pkt(ch, 0, 0);
        end
        drain(500);
`ifdef OUT_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1, 2, 2};
`else
        exp_order = '{0, 1, 2, 0, 1, 2};
`endif
        check_eq("order_len", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check_eq("grant_order", grant_log[i], exp_order[i]);
        check_eq("hdr_only_pops", pop_cnt[0] + pop_cnt[1] + pop_cnt[2], 6);

        // Single ch1 packet 03 A1 A2 A3, sink acks one cycle after req
        clear_logs();
        t1_bytes = '{8'h03, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 4; i++) fifo_push(1, t1_bytes[i]);
        update_fifo_if();
        drain(200);
        check_eq("t1_pops_ch1", pop_cnt[1], 4);
        check_eq("t1_pops_other", pop_cnt[0] + pop_cnt[2], 0);
        check_eq("t1_len", byte_log.size(), 4);
        for (int i = 0; i < 4 && i < byte_log.size(); i++) check_eq("t1_byte", byte_log[i], t1_bytes[i]);
        check_eq("t1_grant", (grant_log.size() == 1) ? grant_log[0] : -1, 1);

        // CRC packet, crc_en dropped after the header has gone
        clear_logs();
        crc_en = 1'b1;
        push_pkt(2, 2, 1);
        n = 0;
        while (!(cur_ch >= 0 && !hdr_pending) && n < 200) begin
            cycle();
            n++;
        end
        check_eq("t3_hdr_seen", (cur_ch >= 0 && !hdr_pending), 1);
        crc_en = 1'b0;
        drain(200);
        check_eq("t3_bytes", last_pkt_bytes, 4);
        check_eq("t3_pops", pop_cnt[2], 4);

        // Slow sink: 10-cycle ack delay, extra ack pulses while req is low
        clear_logs();
        dmin = 10; dmax = 10; fixed_delay = 10; wait_chk = 1; spur_rate = 100;
        push_pkt(0, 1, 0);
        drain(300);
        check_eq("t4_pops", pop_cnt[0], 2);
        wait_chk = 0; spur_rate = 0; dmin = 1; dmax = 1;
        pops_before = pop_cnt[0] + pop_cnt[1] + pop_cnt[2];
        force_ack = 1;
        cycle(); cycle(); cycle();
        force_ack = 0;
        cycle(); cycle();
        check_eq("idle_ack_no_pop", pop_cnt[0] + pop_cnt[1] + pop_cnt[2], pops_before);

        // Maximum size with CRC: counter must reach 2^DATA_SIZE without wrapping
        clear_logs();
        crc_en = 1'b1;
        n = pkts_done;
        push_pkt(1, 63, 1);
        drain(1000);
        check_eq("max_bytes", last_pkt_bytes, 65);
        check_eq("max_done_once", pkts_done - n, 1);
        check_eq("max_pops", pop_cnt[1], 65);
        crc_en = 1'b0;

        // Reset in the middle of a payload
        clear_logs();
        push_pkt(1, 16, 0);
        n = 0;
        while (!(cur_ch >= 0 && pkt_bytes >= 3) && n < 300) begin
            cycle();
            n++;
        end
        check_eq("t6_mid_payload", (cur_ch >= 0 && pkt_bytes >= 3), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data_out", data_out, 0);
        check_eq("arst_req", data_out_req, 0);
        check_eq("arst_pop", fifo_pop, 0);
        check_eq("arst_grant", grant, 0);
        check_eq("arst_busy", busy, 0);
        model_reset();
        data_out_ack = 1'b0;
        fq0.delete(); fq1.delete(); fq2.delete();
        push_pkt(2, 1, 0);
        push_pkt(0, 1, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        clear_logs();
        drain(300);
        check_eq("t6_first", (grant_log.size() >= 1) ? grant_log[0] : -1, 0);
        check_eq("t6_second", (grant_log.size() >= 2) ? grant_log[1] : -1, 2);

        // Randomized traffic
        for (int r = 0; r < 4; r++) begin
            crc_en = 1'($urandom_range(1, 0));
            dmin = 1;
            dmax = $urandom_range(4, 1);
            spur_rate = $urandom_range(50, 0);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(7, 0) == 0) push_pkt($urandom_range(2, 0), $urandom_range(7, 0), crc_en);
                cycle();
            end
            drain(4000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
